// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store engine: store/load size codes
// and FSM states.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SWHB_NONE = 2'b00,
    SWHB_W    = 2'b01,
    SWHB_H    = 2'b10,
    SWHB_B    = 2'b11
  } swhb_e;

  typedef enum logic [1:0] {
    LWHB_W = 2'b00,
    LWHB_H = 2'b01,
    LWHB_B = 2'b10
  } lwhb_e;

  typedef enum logic [1:0] {
    MAU_IDLE,
    MAU_REQ,
    MAU_RESP,
    MAU_DONE
  } mau_state_e;

  // Stores are carried internally in the load-size encoding so one lane
  // aligner serves both directions; SWHB_NONE with mem_write falls back to word.
  function automatic lwhb_e store_size(input logic [1:0] swhb);
    case (swhb)
      SWHB_H:  return LWHB_H;
      SWHB_B:  return LWHB_B;
      default: return LWHB_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus: single-outstanding valid/grant/rvalid handshake.
interface mem_access_unit_if #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
);
  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [BE_W-1:0] bus_be;
  logic [XLEN-1:0] bus_wdata;
  logic            bus_gnt;
  logic            bus_rvalid;
  logic [XLEN-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane aligner: byte enables and replicated store data from
// size/offset, plus extraction and sign/zero extension of load data.
module mem_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  lwhb_e           size_i,
  input  logic [1:0]      off_i,
  input  logic            lunsigned_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [BE_W-1:0] be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Halves use only off[1], words ignore the offset: misaligned ops are force-aligned.
  assign byte_v = rdata_i[{off_i, 3'b000} +: 8];
  assign half_v = rdata_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    be_o    = '1;
    wdata_o = wdata_i;
    load_o  = rdata_i;
    case (size_i)
      LWHB_H: begin
        be_o    = BE_W'(2'b11) << {off_i[1], 1'b0};
        wdata_o = {(XLEN/16){wdata_i[15:0]}};
        load_o  = {{(XLEN-16){half_v[15] & ~lunsigned_i}}, half_v};
      end
      LWHB_B: begin
        be_o    = BE_W'(1'b1) << off_i;
        wdata_o = {(XLEN/8){wdata_i[7:0]}};
        load_o  = {{(XLEN-8){byte_v[7] & ~lunsigned_i}}, byte_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one pipeline memory op becomes one bus
// transaction while the pipeline is stalled. Optional misalign trap: MEM_ACCESS_MISALIGN_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_write,
  input  logic            mem_read,
  input  logic [1:0]      swhb,
  input  logic [1:0]      lwhb,
  input  logic            lunsigned,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic [XLEN-1:0] load_data,
`ifdef MEM_ACCESS_MISALIGN_EN
  output logic            misalign,
`endif
  mem_access_unit_if.master bus
);

  mau_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  lwhb_e           size_q, size_d;
  logic            lu_q, lu_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] load_q, load_d;

  logic            req_in;
  lwhb_e           size_in;
  logic            stall_c;
  logic            in_req;
  logic [BE_W-1:0] be_w;
  logic [XLEN-1:0] wd_w;
  logic [XLEN-1:0] ld_w;

  assign req_in  = mem_write | mem_read;
  assign size_in = mem_write ? store_size(swhb) : lwhb_e'(lwhb);

`ifdef MEM_ACCESS_MISALIGN_EN
  logic mis_in;
  logic misalign_c;
  assign mis_in = ((size_in == LWHB_H) && addr[0]) ||
                  ((size_in == LWHB_W) && (addr[1:0] != 2'b00));
  assign misalign = misalign_c & ~reset;
`endif

  mem_lane_align #(
    .XLEN (XLEN),
    .BE_W (BE_W)
  ) u_lane (
    .size_i      (size_q),
    .off_i       (addr_q[1:0]),
    .lunsigned_i (lu_q),
    .wdata_i     (wdata_q),
    .rdata_i     (bus.bus_rdata),
    .be_o        (be_w),
    .wdata_o     (wd_w),
    .load_o      (ld_w)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    lu_d    = lu_q;
    we_d    = we_q;
    load_d  = load_q;
    stall_c = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_EN
    misalign_c = 1'b0;
`endif
    unique case (state_q)
      MAU_IDLE: begin
        if (req_in) begin
          stall_c = 1'b1;
          addr_d  = addr;
          wdata_d = wdata;
          size_d  = size_in;
          lu_d    = lunsigned;
          we_d    = mem_write;
          state_d = MAU_REQ;
`ifdef MEM_ACCESS_MISALIGN_EN
          if (mis_in) begin
            misalign_c = 1'b1;
            load_d     = '0;
            state_d    = MAU_DONE;
          end
`endif
        end
      end
      MAU_REQ: begin
        stall_c = 1'b1;
        if (bus.bus_gnt) state_d = MAU_RESP;
      end
      MAU_RESP: begin
        stall_c = 1'b1;
        if (bus.bus_rvalid) begin
          load_d  = ld_w;
          state_d = MAU_DONE;
        end
      end
      MAU_DONE: state_d = MAU_IDLE;
      default:  state_d = MAU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MAU_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= LWHB_W;
      lu_q    <= 1'b0;
      we_q    <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      lu_q    <= lu_d;
      we_q    <= we_d;
      load_q  <= load_d;
    end
  end

  // IDLE stall is combinational on the request, so reset must mask it directly.
  assign stall     = stall_c & ~reset;
  assign load_data = load_q;

  assign in_req        = (state_q == MAU_REQ);
  assign bus.bus_req   = in_req;
  assign bus.bus_we    = in_req & we_q;
  assign bus.bus_addr  = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign bus.bus_be    = in_req ? be_w : '0;
  assign bus.bus_wdata = in_req ? wd_w : '0;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine. It is the consumer of the decode controller's memory control signals: memwrite, memtoreg, swhb, lwhb and lunsigned.
- Turns one pipeline memory op into a single-outstanding valid/grant/rvalid transaction on the data-memory bus.
- Drives byte enables and lane-shifted store data on the bus.
- Sign- or zero-extends load data.
- Stalls the pipeline until the transaction completes.

Parameters:
- XLEN, 32, data and address width.
- BE_W, XLEN/8, byte-enable width. Fixed at 4 for RV32.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- mem_write  in  1  store request from the MEM-stage pipeline register
- mem_read  in  1  load request (the memtoreg of the MEM stage)
- swhb  in  2  store size: 01 word, 10 half, 11 byte, 00 none
- lwhb  in  2  load size: 00 word, 01 half, 10 byte
- lunsigned  in  1  zero-extend the load
- addr  in  XLEN  effective address (ALU result)
- wdata  in  XLEN  store data (rs2), right-aligned
- stall  out  1  hold IF/ID/EX/MEM
- load_data  out  XLEN  extended load result, valid in the DONE cycle
- bus_req  out  1  request valid
- bus_we  out  1  write
- bus_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
- bus_be  out  BE_W  byte enables
- bus_wdata  out  XLEN  lane-shifted store data
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  response valid (read data or write ack)
- bus_rdata  in  XLEN  read word

Behaviour:
- Reset, asynchronous and active-high:
  - state=IDLE.
  - bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
  - load_data=0, stall=0.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If mem_write|mem_read, latch addr, size, sign, we and wdata, then go to REQ. stall=1 combinationally in this same cycle.
  - If both mem_write and mem_read are set, the store wins.
- REQ:
  - bus_req=1, and all bus outputs come from the latched values.
  - The request holds stable until bus_gnt=1. On gnt, go to RESP.
- RESP:
  - bus_req=0. Wait for bus_rvalid.
  - On rvalid, register load_data from the extracted bytes and go to DONE.
- DONE:
  - stall=0 and load_data is valid.
  - Next cycle returns to IDLE.
  - A new request visible in the DONE cycle is ignored. The pipeline advances in DONE, so the next op appears in IDLE.
- Stall: stall=1 whenever (IDLE with a request) or REQ or RESP.
- Minimum latency, zero-wait bus (gnt in the first REQ cycle, rvalid the next cycle): IDLE→REQ→RESP→DONE, i.e. 3 stall cycles.
- bus_gnt and bus_rvalid asserted together in REQ is treated as gnt only. rvalid is sampled only in RESP.
- bus_rvalid in IDLE or DONE is ignored.
- Byte enables (off=addr[1:0]):
  - word: 1111.
  - half: 0011<<off, with off[0] cleared.
  - byte: 0001<<off.
- Store data: wdata replicated across lanes.
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load extract:
  - byte: rdata[8*off+:8].
  - half: rdata[16*off[1]+:16].
  - Then sign- or zero-extend per lunsigned. Word ignores lunsigned.
- Reset mid-transaction aborts to IDLE. The bus side must tolerate a dropped request.
- Without the optional feature, misaligned addresses are force-aligned:
  - half: addr[0] is ignored.
  - word: addr[1:0] are ignored.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_EN.
- When defined, misalign detection is enabled. Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
- Extra output port misalign (1 bit):
  - Pulses for one cycle in IDLE when a misaligned op is presented.
  - No bus request is issued, and the FSM goes straight to DONE.
  - load_data=0 and no write occurs.
- When undefined, the port is absent and force-alignment applies.

Decomposition:
- Shared defines file holds:
  - SWHB encodings: SWHB_NONE, SWHB_W, SWHB_H, SWHB_B.
  - LWHB encodings: LWHB_W, LWHB_H, LWHB_B.
  - FSM state encodings: MAU_IDLE, MAU_REQ, MAU_RESP, MAU_DONE.
- One natural sub-module, mem_lane_align (combinational):
  - Computes be and shifted wdata from size/offset.
  - Extracts and extends load data.
- The FSM stays in mem_access_unit.

Test Plan:
- sw x=0xDEADBEEF to addr 0x100, gnt immediate, rvalid next cycle → bus_we=1, bus_addr=0x100, be=1111, wdata=0xDEADBEEF; stall high 3 cycles; no further bus_req.
- sb 0x12345678 to 0x203 → be=1000, bus_wdata=0x78787878, bus_addr=0x200.
- lb from 0x101, rdata=0x0000_80FF, lunsigned=0 → load_data=0xFFFFFF80. Same op with lunsigned=1 (lbu) → 0x00000080.
- lh from 0x302, rdata=0xF00D_1234 → 0xFFFFF00D. lhu → 0x0000F00D.
- gnt delayed 4 cycles, rvalid 2 cycles after gnt → bus_req and bus outputs stable throughout REQ; stall deasserts exactly in DONE; a request held in DONE is not re-issued.
- reset asserted while in RESP → all outputs 0 immediately (asynchronous), FSM in IDLE, late rvalid ignored.
- MEM_ACCESS_MISALIGN_EN defined, lw from 0x102 → misalign pulses 1 cycle, no bus_req, stall clears next cycle.
